smith_waterman_dsm_writer: RTL and testbench
============================================

# smith_waterman_dsm_writer

Reports AFU status to host memory. It is the AFU-to-host counterpart of the MMIO CSR path: the host programs `hc_dsm_base` through CSR writes, and this block writes status cache lines back to that DSM region over CCI-P channel 1. It sits between the Smith-Waterman kernel's status handshake and the AFU's c1 Tx/Rx ports, in front of the MPF shim.

## Interface
Parameters:
- `DSM_SLOTS`, default 4: ring of status lines at `hc_dsm_base`; must be a power of 2, between 1 and 256.
- `RSP_TIMEOUT`, default 4096: number of cycles to wait for a write response before flagging an error.

Ports:
- `clk`  in  1  sole clock.
- `reset`  in  1  synchronous, active-low (0 = reset).
- `hc_dsm_base`  in  `t_hc_address`  cache-line address of the DSM region; 0 means unprogrammed.
- `hc_control`  in  `t_hc_control`  bit0 is `start`.
- `status_valid`  in  1  kernel offers a status word.
- `status_data`  in  32  status word.
- `status_ready`  out  1  block accepts the status word.
- `c1_tx`  out  `t_if_ccip_c1_Tx`  memory write request.
- `c1_tx_alm_full`  in  1  channel 1 almost full.
- `c1_rx`  in  `t_if_ccip_c1_Rx`  write responses.
- `dsm_busy`  out  1  FSM is not in IDLE.
- `dsm_err`  out  1  sticky error (base = 0 or timeout).
- `dsm_wr_count`  out  32  number of completed DSM writes.

## Operation
FSM states: IDLE, ISSUE, WAIT_RSP.
- **IDLE**
  - `status_ready` = 1.
  - On `status_valid & status_ready`:
    - If `hc_dsm_base` == 0: set `dsm_err`, drop the word, stay in IDLE.
    - Otherwise capture the status word, the current `seq`, the `cycles` value and the slot, then go to ISSUE.
- **ISSUE**
  - If `c1_tx_alm_full` = 0: pulse `c1_tx.valid` for one cycle, then go to WAIT_RSP.
  - Otherwise hold in ISSUE with `valid` = 0.
- **WAIT_RSP**
  - On `c1_rx.rspValid` with `resp_type` = `eRSP_WRLINE` and `mdata[15:0]` == `seq[15:0]`: increment `dsm_wr_count`, increment `seq`, go to IDLE.
  - Non-matching responses are ignored.
  - If the timeout counter reaches `RSP_TIMEOUT`: set `dsm_err`, increment `seq`, go to IDLE.
- **Write header**
  - `req_type` = `eREQ_WRLINE_I`, `vc_sel` = `eVC_VA`, `cl_len` = `eCL_LEN_1`, `sop` = 1.
  - `address` = `hc_dsm_base` + slot, where slot = `seq` mod `DSM_SLOTS`.
  - `mdata[15:0]` = `seq[15:0]`.
- **Line layout (512 bits)**
  - [31:0] status word.
  - [63:32] `seq`.
  - [127:64] `cycles`.
  - [511:128] zero.
- **Counters**
  - `seq`: 32 bits, wraps modulo 2^32.
  - `cycles`: 64 bits. Cleared on the rising edge of `hc_control.start`, then increments every cycle while `start` = 1, wraps. Holds its value while `start` = 0.
- `dsm_err` is cleared only by reset.

## Timing
- **Reset values:** `status_ready` = 0 during reset; `c1_tx.valid` = 0; `dsm_busy` = 0; `dsm_err` = 0; `dsm_wr_count` = 0; `seq` = 0; `cycles` = 0; state = IDLE. `status_ready` = 1 from the first cycle after reset releases.
- **Issue latency:** handshake in cycle T; `c1_tx.valid` is registered and asserted in T+1 if `alm_full` was 0 in T+1. `c1_tx.valid` is never high for two consecutive cycles.
- **Ready timing:** `status_ready` is combinational from state only. It is 1 in the cycle after a response returns the FSM to IDLE. It never depends on `status_valid`.
- **Simultaneous events:**
  - A response and the timeout in the same cycle: the response wins, no error is flagged.
  - A `start` edge during WAIT_RSP clears `cycles` but does not affect the in-flight line.
- **Slot ring:** slot wraps from `DSM_SLOTS`-1 back to 0.
- **Reset mid-operation:** the FSM returns to IDLE, the pending write is abandoned, and late responses are ignored because the state is not WAIT_RSP.
- The timeout counter clears on entry to WAIT_RSP.

## Structure
- Shared package additions:
  - `t_hc_dsm_line` struct holding the status, seq and cycles fields.
  - `t_hc_dsm_state` enum.
  - Constant `HC_CONTROL_START_BIT` = 0.
  - Default `HC_DSM_SLOTS`.
- Sub-module `smith_waterman_cycle_counter` (start-edge detection plus the 64-bit counter); everything else stays in this module.

## Test plan
- **Basic write:** base = 0x1000, `status_data` = 0xA5A5_0001 → one `c1_tx` write to 0x1000, `mdata` = 0, line [31:0] = 0xA5A50001, [63:32] = 0. After the response, `dsm_wr_count` = 1 and `status_ready` returns to 1.
- **Slot wrap:** `DSM_SLOTS` = 4, five statuses → addresses base+0, 1, 2, 3, 0; `seq` fields 0–4.
- **Almost full:** `alm_full` held high for 10 cycles after the handshake → no `valid` during those cycles; a single `valid` appears the cycle `alm_full` drops.
- **Unprogrammed base:** base = 0, status offered → `dsm_err` = 1, no `c1_tx.valid`, `dsm_wr_count` = 0.
- **Timeout:** `RSP_TIMEOUT` = 16, no response → `dsm_err` = 1 after 16 cycles in WAIT_RSP. The next status uses `seq` = 1. A late response with `mdata` = 0 is ignored.
- **Mid-operation reset:** reset asserted during WAIT_RSP → all outputs return to their reset values; the stale response is ignored; the next status writes to base+0 with `seq` = 0.

Source files
------------

// File: rtl/smith_waterman_dsm_writer_pkg.sv
// Purpose: shared types for the Smith-Waterman DSM status writer (CCI-P c1 subset, DSM line, FSM states).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package smith_waterman_dsm_writer_pkg;

  localparam int HC_DSM_SLOTS         = 4;
  localparam int HC_CONTROL_START_BIT = 0;

  typedef logic [41:0] t_hc_address;   // cache-line address
  typedef logic [31:0] t_hc_control;

  typedef enum logic [3:0] {
    eREQ_WRLINE_I = 4'h0,
    eREQ_WRLINE_M = 4'h1,
    eREQ_WRPUSH_I = 4'h2,
    eREQ_WRFENCE  = 4'h4
  } t_ccip_c1_req;

  typedef enum logic [3:0] {
    eRSP_WRLINE  = 4'h0,
    eRSP_WRFENCE = 4'h4
  } t_ccip_c1_rsp;

  typedef enum logic [1:0] {
    eVC_VA  = 2'b00,
    eVC_VL0 = 2'b01,
    eVC_VH0 = 2'b10,
    eVC_VH1 = 2'b11
  } t_ccip_vc;

  typedef enum logic [1:0] {
    eCL_LEN_1 = 2'b00,
    eCL_LEN_2 = 2'b01,
    eCL_LEN_4 = 2'b11
  } t_ccip_cl_len;

  typedef struct packed {
    t_ccip_vc     vc_sel;
    logic         sop;
    t_ccip_cl_len cl_len;
    t_ccip_c1_req req_type;
    t_hc_address  address;
    logic [15:0]  mdata;
  } t_ccip_c1_req_hdr;

  typedef struct packed {
    t_ccip_c1_req_hdr hdr;
    logic [511:0]     data;
    logic             valid;
  } t_if_ccip_c1_Tx;

  typedef struct packed {
    t_ccip_c1_rsp resp_type;
    logic [15:0]  mdata;
  } t_ccip_c1_rsp_hdr;

  typedef struct packed {
    t_ccip_c1_rsp_hdr hdr;
    logic             rspValid;
  } t_if_ccip_c1_Rx;

  // Status line as written to host memory; status lands in bits [31:0].
  typedef struct packed {
    logic [383:0] pad;
    logic [63:0]  cycles;
    logic [31:0]  seq;
    logic [31:0]  status;
  } t_hc_dsm_line;

  typedef enum logic [1:0] {
    DSM_IDLE,
    DSM_ISSUE,
    DSM_WAIT_RSP
  } t_hc_dsm_state;

endpackage

// File: rtl/smith_waterman_dsm_writer_if.sv
// Purpose: bundles the kernel status handshake and the CCI-P c1 Tx/Rx ports of the DSM writer.
// Latency: n/a (wires only).
// Backpressure: status_ready from the writer; c1_tx_alm_full from the host channel.
// Modports: slave = DSM writer side, master = kernel/host side (testbench).
interface smith_waterman_dsm_writer_if
  import smith_waterman_dsm_writer_pkg::*;
;
  logic           status_valid;
  logic [31:0]    status_data;
  logic           status_ready;
  t_if_ccip_c1_Tx c1_tx;
  logic           c1_tx_alm_full;
  t_if_ccip_c1_Rx c1_rx;

  modport slave (
    input  status_valid, status_data, c1_tx_alm_full, c1_rx,
    output status_ready, c1_tx
  );

  modport master (
    output status_valid, status_data, c1_tx_alm_full, c1_rx,
    input  status_ready, c1_tx
  );
endinterface

// File: rtl/smith_waterman_cycle_counter.sv
// Purpose: 64-bit run-time counter, cleared on a rising edge of start, counting while start is high.
// Latency: cycles reads 0 in the cycle after the start edge is sampled.
// Backpressure: none.
// Ports: clk, reset (sync, active-low), start (level), cycles (64-bit count, holds while start is low).
module smith_waterman_cycle_counter (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic [63:0] cycles
);

  logic start_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      start_q <= 1'b0;
      cycles  <= '0;
    end else begin
      start_q <= start;
      if (start && !start_q) begin
        cycles <= '0;
      end else if (start) begin
        cycles <= cycles + 64'd1;
      end
    end
  end

endmodule

// File: rtl/smith_waterman_dsm_writer.sv
// Purpose: writes kernel status words as cache lines into a DSM ring in host memory over CCI-P c1.
// Latency: c1_tx.valid in the cycle after the status handshake (later if c1_tx_alm_full is high).
// Backpressure: one write in flight; status_ready only in IDLE; c1_tx_alm_full stalls issue.
// Ports: clk, reset (sync, active-low), hc_dsm_base/hc_control from CSRs, bus (status handshake + c1 Tx/Rx),
//        dsm_busy (FSM not idle), dsm_err (sticky: base unprogrammed or response timeout), dsm_wr_count.
// DSM_SLOTS must be a power of two in 1..256; the slot is taken by masking seq.
module smith_waterman_dsm_writer
  import smith_waterman_dsm_writer_pkg::*;
#(
  parameter int DSM_SLOTS   = HC_DSM_SLOTS,
  parameter int RSP_TIMEOUT = 4096
) (
  input  logic                        clk,
  input  logic                        reset,
  input  t_hc_address                 hc_dsm_base,
  input  t_hc_control                 hc_control,
  smith_waterman_dsm_writer_if.slave  bus,
  output logic                        dsm_busy,
  output logic                        dsm_err,
  output logic [31:0]                 dsm_wr_count
);

  t_hc_dsm_state state_q, state_d;
  logic          active_q;      // low for the first cycle out of reset so status_ready stays 0 in reset
  logic [31:0]   seq_q;
  logic [31:0]   tmo_q;
  t_hc_dsm_line  line_q;
  t_hc_address   addr_q;
  logic [63:0]   cycles;
  logic [31:0]   slot;
  logic          accept;
  logic          rsp_match;
  logic          tmo_hit;
  logic          tx_valid;
  logic          unused_ctrl;

  assign unused_ctrl = ^hc_control[31:1];

  smith_waterman_cycle_counter u_cycle_counter (
    .clk    (clk),
    .reset  (reset),
    .start  (hc_control[HC_CONTROL_START_BIT]),
    .cycles (cycles)
  );

  assign bus.status_ready = active_q && (state_q == DSM_IDLE);
  assign accept           = bus.status_valid && bus.status_ready;
  assign slot             = seq_q & 32'(DSM_SLOTS - 1);
  assign rsp_match        = bus.c1_rx.rspValid
                            && (bus.c1_rx.hdr.resp_type == eRSP_WRLINE)
                            && (bus.c1_rx.hdr.mdata == seq_q[15:0]);
  // tmo_q counts completed WAIT_RSP cycles, so this fires on the RSP_TIMEOUT-th cycle.
  assign tmo_hit          = (tmo_q == 32'(RSP_TIMEOUT - 1));
  assign dsm_busy         = (state_q != DSM_IDLE);

  always_comb begin
    state_d  = state_q;
    tx_valid = 1'b0;
    case (state_q)
      DSM_IDLE: begin
        if (accept && (hc_dsm_base != '0)) begin
          state_d = DSM_ISSUE;
        end
      end
      DSM_ISSUE: begin
        if (!bus.c1_tx_alm_full) begin
          tx_valid = 1'b1;
          state_d  = DSM_WAIT_RSP;
        end
      end
      DSM_WAIT_RSP: begin
        // A matching response in the timeout cycle still counts as success.
        if (rsp_match || tmo_hit) begin
          state_d = DSM_IDLE;
        end
      end
      default: state_d = DSM_IDLE;
    endcase
  end

  always_comb begin
    bus.c1_tx                  = '0;
    bus.c1_tx.hdr.vc_sel       = eVC_VA;
    bus.c1_tx.hdr.sop          = 1'b1;
    bus.c1_tx.hdr.cl_len       = eCL_LEN_1;
    bus.c1_tx.hdr.req_type     = eREQ_WRLINE_I;
    bus.c1_tx.hdr.address      = addr_q;
    bus.c1_tx.hdr.mdata        = seq_q[15:0];
    bus.c1_tx.data             = line_q;
    bus.c1_tx.valid            = tx_valid;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= DSM_IDLE;
      active_q     <= 1'b0;
      seq_q        <= '0;
      tmo_q        <= '0;
      line_q       <= '0;
      addr_q       <= '0;
      dsm_err      <= 1'b0;
      dsm_wr_count <= '0;
    end else begin
      state_q  <= state_d;
      active_q <= 1'b1;

      if (accept) begin
        if (hc_dsm_base == '0) begin
          dsm_err <= 1'b1;
        end else begin
          // Line contents are frozen here; later start edges do not touch the in-flight write.
          line_q <= '{pad: '0, cycles: cycles, seq: seq_q, status: bus.status_data};
          addr_q <= hc_dsm_base + t_hc_address'(slot);
        end
      end

      if (state_q == DSM_WAIT_RSP) begin
        tmo_q <= tmo_q + 32'd1;
        if (rsp_match) begin
          dsm_wr_count <= dsm_wr_count + 32'd1;
          seq_q        <= seq_q + 32'd1;
        end else if (tmo_hit) begin
          dsm_err <= 1'b1;
          seq_q   <= seq_q + 32'd1;
        end
      end else begin
        tmo_q <= '0;
      end
    end
  end

endmodule

// File: tb/tb_smith_waterman_dsm_writer.sv
module tb_smith_waterman_dsm_writer;
  import smith_waterman_dsm_writer_pkg::*;

  localparam int SLOTS = 4;
  localparam int TMO   = 16;

  logic        clk = 1'b0;
  logic        reset;
  t_hc_address hc_dsm_base;
  t_hc_control hc_control;
  logic        dsm_busy;
  logic        dsm_err;
  logic [31:0] dsm_wr_count;

  smith_waterman_dsm_writer_if bus ();

  smith_waterman_dsm_writer #(.DSM_SLOTS(SLOTS), .RSP_TIMEOUT(TMO)) dut (
    .clk          (clk),
    .reset        (reset),
    .hc_dsm_base  (hc_dsm_base),
    .hc_control   (hc_control),
    .bus          (bus.slave),
    .dsm_busy     (dsm_busy),
    .dsm_err      (dsm_err),
    .dsm_wr_count (dsm_wr_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int r_cyc = 0;        // cycle in which start was last raised
  int n_valid = 0;      // c1_tx.valid pulses seen
  int exp_valids = 0;   // pulses the reference model expects
  logic prev_valid = 1'b0;

  // Reference model state
  logic [31:0] seq_m = 0;
  logic [31:0] cnt_m = 0;
  logic        err_m = 0;

  typedef struct {
    logic [31:0] d;
    int          alm;
    int          delay;
    bit          bogus;
    int          exp_slot;
    logic [31:0] exp_seq;
  } vec_t;
  vec_t vecs[5];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (bus.c1_tx.valid === 1'b1) begin
      n_valid++;
      chk("valid_not_back_to_back", 128'(prev_valid), 128'(1'b0));
    end
    prev_valid = (bus.c1_tx.valid === 1'b1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_rise();
    hc_control = '0;
    tick();
    hc_control[HC_CONTROL_START_BIT] = 1'b1;
    r_cyc = cyc;
    tick();
  endtask

  // Offer a status word; returns the handshake cycle. Leaves us 1 cycle after it.
  task automatic offer(input logic [31:0] d, output int t, output bit ok);
    ok = 1'b0;
    t  = 0;
    bus.status_valid = 1'b1;
    bus.status_data  = d;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (bus.status_ready === 1'b1) begin
        ok = 1'b1;
        t  = cyc;
      end
      tick();
    end
    bus.status_valid = 1'b0;
    chk("handshake", 128'(ok), 128'(1'b1));
  endtask

  task automatic issue_and_check(input int alm, input logic [31:0] d, input logic [31:0] exp_seq,
                                 input t_hc_address exp_addr, input int t);
    bus.c1_tx_alm_full = (alm > 0);
    for (int i = 0; i < alm; i++) begin
      @(negedge clk);
      chk("valid_held_by_alm_full", 128'(bus.c1_tx.valid), 128'(1'b0));
      tick();
    end
    bus.c1_tx_alm_full = 1'b0;
    @(negedge clk);
    exp_valids++;
    chk("tx_valid", 128'(bus.c1_tx.valid), 128'(1'b1));
    chk("tx_addr", 128'(bus.c1_tx.hdr.address), 128'(exp_addr));
    chk("tx_mdata", 128'(bus.c1_tx.hdr.mdata), 128'(exp_seq[15:0]));
    chk("tx_req_type", 128'(bus.c1_tx.hdr.req_type), 128'(eREQ_WRLINE_I));
    chk("tx_vc_len_sop", 128'({bus.c1_tx.hdr.vc_sel, bus.c1_tx.hdr.cl_len, bus.c1_tx.hdr.sop}),
        128'({eVC_VA, eCL_LEN_1, 1'b1}));
    chk("line_status", 128'(bus.c1_tx.data[31:0]), 128'(d));
    chk("line_seq", 128'(bus.c1_tx.data[63:32]), 128'(exp_seq));
    chk("line_cycles", 128'(bus.c1_tx.data[127:64]), 128'(64'(t - r_cyc - 1)));
    chk("line_pad_zero", 128'(|bus.c1_tx.data[511:128]), 128'(1'b0));
    tick();
  endtask

  // Called in the first WAIT_RSP cycle; the matching response arrives in WAIT cycle 'delay'.
  task automatic respond(input int delay, input bit bogus, input logic [15:0] tag);
    for (int i = 1; i <= delay; i++) begin
      bus.c1_rx = '0;
      if (i == delay) begin
        bus.c1_rx.rspValid = 1'b1;
        bus.c1_rx.hdr.resp_type = eRSP_WRLINE;
        bus.c1_rx.hdr.mdata = tag;
      end else if (bogus && i == 1) begin
        bus.c1_rx.rspValid = 1'b1;
        bus.c1_rx.hdr.resp_type = eRSP_WRLINE;
        bus.c1_rx.hdr.mdata = tag ^ 16'h0001;
      end else if (bogus && i == 2) begin
        bus.c1_rx.rspValid = 1'b1;
        bus.c1_rx.hdr.resp_type = eRSP_WRFENCE;
        bus.c1_rx.hdr.mdata = tag;
      end
      @(negedge clk);
      if (bogus && (i == 2 || i == 3)) begin
        chk("bogus_rsp_ignored", 128'({dsm_busy, dsm_wr_count}), 128'({1'b1, cnt_m}));
      end
      tick();
    end
    bus.c1_rx = '0;
    seq_m++;
    cnt_m++;
    @(negedge clk);
    chk("ready_after_rsp", 128'({bus.status_ready, dsm_busy}), 128'({1'b1, 1'b0}));
    chk("wr_count", 128'(dsm_wr_count), 128'(cnt_m));
    chk("err_state", 128'(dsm_err), 128'(err_m));
    tick();
  endtask

  task automatic full_write(input logic [31:0] d, input int alm, input int delay, input bit bogus,
                            input logic [31:0] exp_seq, input t_hc_address exp_addr);
    int t;
    bit ok;
    offer(d, t, ok);
    if (!ok) return;
    issue_and_check(alm, d, exp_seq, exp_addr, t);
    respond(delay, bogus, exp_seq[15:0]);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach its end (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    bit ok;
    logic [31:0] b;
    logic [15:0] stale;

    vecs[0] = '{32'hA5A5_0001, 0,  2, 1'b0, 0, 32'd0};
    vecs[1] = '{32'h5A5A_0002, 0,  3, 1'b1, 1, 32'd1};
    vecs[2] = '{32'h1234_5678, 1,  1, 1'b0, 2, 32'd2};
    vecs[3] = '{32'hDEAD_BEEF, 10, 5, 1'b1, 3, 32'd3};
    vecs[4] = '{32'h0F0F_0F0F, 0, 16, 1'b0, 0, 32'd4};   // response lands on the timeout cycle

    reset = 1'b0;
    hc_control = '0;
    hc_dsm_base = 42'h1000;
    bus.status_valid = 1'b0;
    bus.status_data = '0;
    bus.c1_tx_alm_full = 1'b0;
    bus.c1_rx = '0;

    repeat (3) tick();
    @(negedge clk);
    chk("reset_ready", 128'(bus.status_ready), 128'(1'b0));
    chk("reset_outputs", 128'({bus.c1_tx.valid, dsm_busy, dsm_err, dsm_wr_count}), 128'(0));
    tick();
    reset = 1'b1;
    tick();
    @(negedge clk);
    chk("ready_after_reset", 128'(bus.status_ready), 128'(1'b1));
    tick();

    start_rise();

    // Basic write, slot wrap, almost-full, bogus responses, response-on-timeout.
    for (int i = 0; i < 5; i++) begin
      full_write(vecs[i].d, vecs[i].alm, vecs[i].delay, vecs[i].bogus, vecs[i].exp_seq,
                 42'h1000 + t_hc_address'(vecs[i].exp_slot));
    end

    // Randomized writes against the model.
    for (int n = 0; n < 24; n++) begin
      int dly;
      if ($urandom_range(0, 3) == 0) begin
        do b = $urandom; while (b == 0);
        hc_dsm_base = {10'h3, b};
      end
      if ($urandom_range(0, 3) == 0) start_rise();
      dly = $urandom_range(1, TMO);
      full_write($urandom, $urandom_range(0, 3), dly, (dly >= 3) && ($urandom_range(0, 1) == 1),
                 seq_m, hc_dsm_base + t_hc_address'(seq_m % SLOTS));
    end

    // Timeout: no response.
    hc_dsm_base = 42'h1000;
    stale = seq_m[15:0];
    offer(32'h7100_0001, t, ok);
    issue_and_check(0, 32'h7100_0001, seq_m, hc_dsm_base + t_hc_address'(seq_m % SLOTS), t);
    for (int i = 1; i < TMO; i++) tick();
    @(negedge clk);
    chk("no_err_before_timeout", 128'({dsm_err, dsm_busy}), 128'({1'b0, 1'b1}));
    tick();
    @(negedge clk);
    chk("err_at_timeout", 128'({dsm_err, dsm_busy}), 128'({1'b1, 1'b0}));
    seq_m++;
    err_m = 1'b1;
    tick();
    bus.c1_rx = '0;
    bus.c1_rx.rspValid = 1'b1;
    bus.c1_rx.hdr.resp_type = eRSP_WRLINE;
    bus.c1_rx.hdr.mdata = stale;
    tick();
    bus.c1_rx = '0;
    @(negedge clk);
    chk("late_rsp_ignored", 128'(dsm_wr_count), 128'(cnt_m));
    tick();
    full_write(32'h7100_0002, 0, 4, 1'b0, seq_m, hc_dsm_base + t_hc_address'(seq_m % SLOTS));

    // Reset while waiting for a response.
    stale = seq_m[15:0];
    offer(32'hCAFE_0001, t, ok);
    issue_and_check(0, 32'hCAFE_0001, seq_m, hc_dsm_base + t_hc_address'(seq_m % SLOTS), t);
    reset = 1'b0;
    hc_control = '0;
    tick();
    @(negedge clk);
    chk("midreset_ready", 128'(bus.status_ready), 128'(1'b0));
    chk("midreset_outputs", 128'({bus.c1_tx.valid, dsm_busy, dsm_err, dsm_wr_count}), 128'(0));
    tick();
    reset = 1'b1;
    bus.c1_rx = '0;
    bus.c1_rx.rspValid = 1'b1;
    bus.c1_rx.hdr.resp_type = eRSP_WRLINE;
    bus.c1_rx.hdr.mdata = stale;
    tick();
    bus.c1_rx.hdr.mdata = 16'h0000;
    tick();
    bus.c1_rx = '0;
    @(negedge clk);
    chk("stale_rsp_ignored", 128'({dsm_busy, dsm_wr_count}), 128'(0));
    chk("ready_after_midreset", 128'(bus.status_ready), 128'(1'b1));
    tick();
    seq_m = 0;
    cnt_m = 0;
    err_m = 1'b0;
    start_rise();
    full_write(32'hCAFE_0002, 0, 2, 1'b0, 32'd0, hc_dsm_base);

    // Unprogrammed base.
    hc_dsm_base = '0;
    offer(32'hBAD0_BA5E, t, ok);
    @(negedge clk);
    chk("base0_err", 128'({dsm_err, dsm_busy, bus.status_ready}), 128'({1'b1, 1'b0, 1'b1}));
    repeat (4) tick();
    @(negedge clk);
    chk("base0_no_write", 128'(dsm_wr_count), 128'(cnt_m));
    chk("valid_count", 128'(n_valid), 128'(exp_valids));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
